atm_fsm: RTL and testbench
==========================

Name: atm_fsm

Overview:
Moore-style control FSM for an ATM session: card insertion, PIN acceptance, menu choice between cash withdrawal and balance enquiry, completion, and optional chaining of further transactions before card ejection. All decision inputs are single-bit status flags from the host/bank interface. Outputs drive the card mechanism, the cash dispenser and the receipt printer, plus a 3-bit display code equal to the current state. No datapath; amounts and balances are handled outside this block.

Parameters:
none

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
card_in  input  1  card present in slot
pin_check  input  1  PIN verified correct
withdraw1_or_balanceenq0  input  1  menu choice: 1 = withdrawal, 0 = balance enquiry
currentbalance1_ministatement0  input  1  enquiry type: 1 = current balance, 0 = mini statement
amount  input  1  withdrawal amount entered/valid
transaction_success  input  1  bank approved and completed withdrawal
balance_enquiry_success  input  1  bank returned enquiry data
new_transaction  input  1  customer requests another transaction
card_eject  output  1  one-cycle pulse: eject card
cash_out  output  1  one-cycle pulse: dispense cash
receipt_out  output  1  one-cycle pulse: print receipt
display  output  3  current state code

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset has priority over all inputs: state = IDLE, card_eject = cash_out = receipt_out = 0, display = 3'b000, internal enquiry-mode register = 0.
- State encoding (display = state register, registered, no combinational path from inputs):
  0 IDLE, 1 PIN_WAIT, 2 MENU, 3 AMOUNT_ENTRY, 4 WITHDRAW_PROC, 5 BAL_SELECT, 6 BAL_PROC, 7 TXN_END.
- Transitions, evaluated on each rising clk edge; conditions not listed mean stay in state:
  IDLE: card_in=1 -> PIN_WAIT.
  PIN_WAIT: card_in=0 -> IDLE (card withdrawn, no eject pulse); else pin_check=1 -> MENU.
  MENU: withdraw1_or_balanceenq0=1 -> AMOUNT_ENTRY; =0 -> BAL_SELECT. MENU always lasts exactly one cycle.
  AMOUNT_ENTRY: amount=1 -> WITHDRAW_PROC.
  WITHDRAW_PROC: transaction_success=1 -> TXN_END.
  BAL_SELECT: always -> BAL_PROC after one cycle; latches currentbalance1_ministatement0 into the mode register on that edge.
  BAL_PROC: balance_enquiry_success=1 -> TXN_END.
  TXN_END: new_transaction=1 -> MENU; else -> IDLE.
- Outputs are registered pulses, high for exactly one cycle, in the cycle after the qualifying edge:
  cash_out and receipt_out: both 1 in the first cycle of TXN_END entered from WITHDRAW_PROC.
  receipt_out: 1 in the first cycle of TXN_END entered from BAL_PROC when the mode register = 0 (mini statement). Current-balance mode (mode register = 1) produces no receipt.
  card_eject: 1 in the first cycle of IDLE entered from TXN_END. It does not pulse on reset or on PIN_WAIT abort.
  All outputs are 0 in every other cycle.
- Simultaneous inputs: only the flags named for the current state are examined; all other inputs are ignored. Within PIN_WAIT, card removal beats pin_check.
- Reset asserted mid-session returns to IDLE on the next edge with all pulses cleared.

Test Plan:
- Reset held 2 cycles -> display=000, all outputs 0; release with all inputs 0 -> stays 000.
- Withdrawal: card_in=1 -> display 001; pin_check=1 -> 010; withdraw=1 held -> 011; amount=1 -> 100; transaction_success=1 -> 111 with cash_out=1, receipt_out=1 for one cycle; new_transaction=0 -> 000 with card_eject=1 for one cycle.
- Balance enquiry, mini statement: in MENU with withdraw=0 -> 101 -> 110; balance_enquiry_success=1 -> 111 with receipt_out=1, cash_out=0. Repeat with currentbalance1_ministatement0=1 -> no receipt_out pulse.
- Chaining: in TXN_END with new_transaction=1 -> display 010 (MENU), no card_eject; then second transaction completes normally.
- Abort: in PIN_WAIT drop card_in with pin_check=1 -> display 000, card_eject stays 0.
- Reset mid-operation in WITHDRAW_PROC with transaction_success=1 on the same edge -> display 000, cash_out=0.

Source files
------------

// File: rtl/atm_fsm.sv
// ATM session controller: card/PIN handling, withdrawal or balance enquiry,
// optional chaining of transactions, then card ejection. Outputs are registered.
module atm_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       card_in,
    input  logic       pin_check,
    input  logic       withdraw1_or_balanceenq0,
    input  logic       currentbalance1_ministatement0,
    input  logic       amount,
    input  logic       transaction_success,
    input  logic       balance_enquiry_success,
    input  logic       new_transaction,
    output logic       card_eject,
    output logic       cash_out,
    output logic       receipt_out,
    output logic [2:0] display
);

    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_PIN_WAIT      = 3'd1;
    localparam logic [2:0] ST_MENU          = 3'd2;
    localparam logic [2:0] ST_AMOUNT_ENTRY  = 3'd3;
    localparam logic [2:0] ST_WITHDRAW_PROC = 3'd4;
    localparam logic [2:0] ST_BAL_SELECT    = 3'd5;
    localparam logic [2:0] ST_BAL_PROC      = 3'd6;
    localparam logic [2:0] ST_TXN_END       = 3'd7;

    logic [2:0] state_q, state_d;
    logic       mode_q, mode_d;
    logic       card_eject_q, card_eject_d;
    logic       cash_out_q, cash_out_d;
    logic       receipt_out_q, receipt_out_d;

    // Next-state and next-pulse logic; pulses are decided by the transition taken.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        card_eject_d  = 1'b0;
        cash_out_d    = 1'b0;
        receipt_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (card_in) begin
                    state_d = ST_PIN_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PIN_WAIT: begin
                // Card removal wins over a simultaneous PIN acceptance.
                if (!card_in) begin
                    state_d = ST_IDLE;
                end else if (pin_check) begin
                    state_d = ST_MENU;
                end else begin
                    state_d = ST_PIN_WAIT;
                end
            end
            ST_MENU: begin
                if (withdraw1_or_balanceenq0) begin
                    state_d = ST_AMOUNT_ENTRY;
                end else begin
                    state_d = ST_BAL_SELECT;
                end
            end
            ST_AMOUNT_ENTRY: begin
                if (amount) begin
                    state_d = ST_WITHDRAW_PROC;
                end else begin
                    state_d = ST_AMOUNT_ENTRY;
                end
            end
            ST_WITHDRAW_PROC: begin
                if (transaction_success) begin
                    state_d       = ST_TXN_END;
                    cash_out_d    = 1'b1;
                    receipt_out_d = 1'b1;
                end else begin
                    state_d = ST_WITHDRAW_PROC;
                end
            end
            ST_BAL_SELECT: begin
                state_d = ST_BAL_PROC;
                mode_d  = currentbalance1_ministatement0;
            end
            ST_BAL_PROC: begin
                // Only a mini statement produces a printed receipt.
                if (balance_enquiry_success) begin
                    state_d       = ST_TXN_END;
                    receipt_out_d = ~mode_q;
                end else begin
                    state_d = ST_BAL_PROC;
                end
            end
            ST_TXN_END: begin
                if (new_transaction) begin
                    state_d = ST_MENU;
                end else begin
                    state_d      = ST_IDLE;
                    card_eject_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, enquiry mode and output pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            card_eject_q  <= 1'b0;
            cash_out_q    <= 1'b0;
            receipt_out_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            card_eject_q  <= card_eject_d;
            cash_out_q    <= cash_out_d;
            receipt_out_q <= receipt_out_d;
        end
    end

    assign card_eject  = card_eject_q;
    assign cash_out    = cash_out_q;
    assign receipt_out = receipt_out_q;
    assign display     = state_q;

endmodule

// File: tb/tb_atm_fsm.sv
// Self-checking bench for atm_fsm: directed session scenarios followed by
// randomized inputs, compared against a table-driven session model.
module tb_atm_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_v;
    logic       card_eject, cash_out, receipt_out;
    logic [2:0] display;

    int tests = 0;
    int fails = 0;

    // Flag bits of in_v: 0 card, 1 pin, 2 withdraw, 3 curbal, 4 amount, 5 txn_ok, 6 bal_ok, 7 new_txn.
    // Session model: per state, which flag decides, and where a 1 / 0 leads.
    // Flag index 8 is a constant 1 (unconditional move).
    int gate [8] = '{0, 0, 2, 4, 5, 8, 6, 7};
    int dst1 [8] = '{1, 1, 3, 4, 7, 6, 7, 2};
    int dst0 [8] = '{0, 1, 5, 3, 4, 6, 6, 0};
    int ms;
    bit mm;
    bit e_ej, e_cash, e_rc;

    atm_fsm dut (
        .clk                            (clk),
        .reset                          (reset),
        .card_in                        (in_v[0]),
        .pin_check                      (in_v[1]),
        .withdraw1_or_balanceenq0       (in_v[2]),
        .currentbalance1_ministatement0 (in_v[3]),
        .amount                         (in_v[4]),
        .transaction_success            (in_v[5]),
        .balance_enquiry_success        (in_v[6]),
        .new_transaction                (in_v[7]),
        .card_eject                     (card_eject),
        .cash_out                       (cash_out),
        .receipt_out                    (receipt_out),
        .display                        (display)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int       nxt;
        bit [8:0] flags;
        if (reset) begin
            ms = 0; mm = 1'b0; e_ej = 1'b0; e_cash = 1'b0; e_rc = 1'b0;
        end else begin
            flags = {1'b1, in_v};
            if (ms == 1)
                nxt = !in_v[0] ? 0 : (in_v[1] ? 2 : 1);
            else
                nxt = flags[gate[ms]] ? dst1[ms] : dst0[ms];
            // Pulses are properties of the session event just completed.
            e_cash = (ms == 4) && (nxt == 7);
            e_rc   = e_cash || ((ms == 6) && (nxt == 7) && !mm);
            e_ej   = (ms == 7) && (nxt == 0);
            if (ms == 5) mm = in_v[3];
            ms = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".display"}, {5'd0, display}, 8'(ms));
        check({tag, ".cash"}, {7'd0, cash_out}, {7'd0, e_cash});
        check({tag, ".receipt"}, {7'd0, receipt_out}, {7'd0, e_rc});
        check({tag, ".eject"}, {7'd0, card_eject}, {7'd0, e_ej});
    endtask

    task automatic expect_bits(input string tag, input logic [2:0] d, input logic c, input logic r, input logic e);
        check({tag, ".d"}, {5'd0, display}, {5'd0, d});
        check({tag, ".c"}, {7'd0, cash_out}, {7'd0, c});
        check({tag, ".r"}, {7'd0, receipt_out}, {7'd0, r});
        check({tag, ".e"}, {7'd0, card_eject}, {7'd0, e});
    endtask

    initial begin
        ms = 0; mm = 1'b0; e_ej = 1'b0; e_cash = 1'b0; e_rc = 1'b0;
        reset = 1'b1;
        in_v  = 8'h00;
        step("rst1");
        step("rst2");
        expect_bits("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step("idle");
        expect_bits("idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Withdrawal session
        in_v = 8'h01; step("wd_card");  expect_bits("wd_card", 3'd1, 1'b0, 1'b0, 1'b0);
        in_v = 8'h03; step("wd_pin");   expect_bits("wd_pin", 3'd2, 1'b0, 1'b0, 1'b0);
        in_v = 8'h05; step("wd_menu");  expect_bits("wd_menu", 3'd3, 1'b0, 1'b0, 1'b0);
        in_v = 8'h15; step("wd_amt");   expect_bits("wd_amt", 3'd4, 1'b0, 1'b0, 1'b0);
        in_v = 8'h21; step("wd_ok");    expect_bits("wd_ok", 3'd7, 1'b1, 1'b1, 1'b0);
        in_v = 8'h00; step("wd_end");   expect_bits("wd_end", 3'd0, 1'b0, 1'b0, 1'b1);
        step("wd_after");               expect_bits("wd_after", 3'd0, 1'b0, 1'b0, 1'b0);

        // Mini statement, then chained current-balance enquiry
        in_v = 8'h01; step("ms_card");
        in_v = 8'h03; step("ms_pin");
        in_v = 8'h01; step("ms_menu");  expect_bits("ms_menu", 3'd5, 1'b0, 1'b0, 1'b0);
        step("ms_sel");                 expect_bits("ms_sel", 3'd6, 1'b0, 1'b0, 1'b0);
        in_v = 8'h41; step("ms_ok");    expect_bits("ms_ok", 3'd7, 1'b0, 1'b1, 1'b0);
        in_v = 8'h81; step("chain");    expect_bits("chain", 3'd2, 1'b0, 1'b0, 1'b0);
        in_v = 8'h09; step("cb_menu");  expect_bits("cb_menu", 3'd5, 1'b0, 1'b0, 1'b0);
        step("cb_sel");                 expect_bits("cb_sel", 3'd6, 1'b0, 1'b0, 1'b0);
        in_v = 8'h41; step("cb_ok");    expect_bits("cb_ok", 3'd7, 1'b0, 1'b0, 1'b0);
        in_v = 8'h00; step("cb_end");   expect_bits("cb_end", 3'd0, 1'b0, 1'b0, 1'b1);

        // Abort in PIN_WAIT: card removal beats pin_check, no eject
        in_v = 8'h01; step("ab_card");
        in_v = 8'h02; step("abort");    expect_bits("abort", 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset wins over a completing withdrawal
        in_v = 8'h01; step("mr_card");
        in_v = 8'h03; step("mr_pin");
        in_v = 8'h05; step("mr_menu");
        in_v = 8'h15; step("mr_amt");   expect_bits("mr_amt", 3'd4, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; in_v = 8'h21;
        step("mr_rst");                 expect_bits("mr_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; in_v = 8'h00;
        step("mr_idle");

        // Randomized sessions against the model
        for (int i = 0; i < 400; i++) begin
            in_v    = 8'($urandom);
            in_v[0] = ($urandom_range(0, 7) != 0);
            reset   = ($urandom_range(0, 59) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
